// File: rtl/output_buffer_ctrl.sv
// rtl/output_buffer_ctrl.sv - 16-entry output buffer FIFO controller with drain FSM
module output_buffer_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       res_valid,
  output logic       res_ready,
  input  logic       drain_start,
  input  logic [4:0] drain_count,
  input  logic       ext_ready,
  output logic       ext_valid,
  output logic       op_buffer_instr_for_storing_data,
  output logic [3:0] op_buf_addr_for_store,
  output logic       op_buffer_instr_for_sending_data,
  output logic [3:0] op_buf_addr_for_external_comm,
  output logic [4:0] count,
  output logic       full,
  output logic       empty,
  output logic       drain_done,
  output logic       drain_err
);

  typedef enum logic [1:0] {IDLE, RD, WAIT, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] wr_ptr_q, wr_ptr_d;
  logic [3:0] rd_ptr_q, rd_ptr_d;
  logic [4:0] count_q, count_d;
  logic [4:0] remaining_q, remaining_d;
  logic       drain_err_q, drain_err_d;
  logic       store;
  logic       send;

  // Output decode: strobes and flags come straight from registered state, so a
  // read cycle always blocks the store path and reset forces every output idle.
  always_comb begin
    full      = (count_q == 5'd16);
    empty     = (count_q == 5'd0);
    res_ready = rst && !full && (state_q != RD);
    store     = res_valid && res_ready;
    send      = (state_q == RD);

    op_buffer_instr_for_storing_data = store;
    op_buf_addr_for_store            = wr_ptr_q;
    op_buffer_instr_for_sending_data = send;
    op_buf_addr_for_external_comm    = rd_ptr_q;
    ext_valid                        = (state_q == WAIT);
    drain_done                       = (state_q == DONE);
    drain_err                        = drain_err_q;
    count                            = count_q;
  end

  // Next-state logic: drain sequencing plus pointer/occupancy bookkeeping.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    drain_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (drain_start) begin
          if ((drain_count != 5'd0) && (drain_count <= count_q)) begin
            remaining_d = drain_count;
            state_d     = RD;
          end else begin
            drain_err_d = 1'b1;
          end
        end
      end
      RD: begin
        rd_ptr_d = rd_ptr_q + 4'd1;
        state_d  = WAIT;
      end
      WAIT: begin
        // The buffer word registered at the RD edge is held until taken.
        if (ext_ready) begin
          remaining_d = remaining_q - 5'd1;
          state_d     = (remaining_q == 5'd1) ? DONE : RD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // store and send are mutually exclusive because res_ready is low in RD.
    if (store) begin
      wr_ptr_d = wr_ptr_q + 4'd1;
      count_d  = count_q + 5'd1;
    end else if (send) begin
      count_d = count_q - 5'd1;
    end
  end

  // State registers, asynchronously cleared so a drain is abandoned on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= 4'd0;
      rd_ptr_q    <= 4'd0;
      count_q     <= 5'd0;
      remaining_q <= 5'd0;
      drain_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      drain_err_q <= drain_err_d;
    end
  end

endmodule

// File: tb/tb_output_buffer_ctrl.sv
// tb/tb_output_buffer_ctrl.sv - self-checking bench for output_buffer_ctrl
module tb_output_buffer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       res_valid;
  logic       res_ready;
  logic       drain_start;
  logic [4:0] drain_count;
  logic       ext_ready;
  logic       ext_valid;
  logic       st_stb;
  logic [3:0] st_addr;
  logic       sd_stb;
  logic [3:0] sd_addr;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       drain_done;
  logic       drain_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  output_buffer_ctrl dut (
    .clk                              (clk),
    .rst                              (rst),
    .res_valid                        (res_valid),
    .res_ready                        (res_ready),
    .drain_start                      (drain_start),
    .drain_count                      (drain_count),
    .ext_ready                        (ext_ready),
    .ext_valid                        (ext_valid),
    .op_buffer_instr_for_storing_data (st_stb),
    .op_buf_addr_for_store            (st_addr),
    .op_buffer_instr_for_sending_data (sd_stb),
    .op_buf_addr_for_external_comm    (sd_addr),
    .count                            (count),
    .full                             (full),
    .empty                            (empty),
    .drain_done                       (drain_done),
    .drain_err                        (drain_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: occupancy, pointers as plain modulo-16 counters, and a
  // drain tracked as "words left" plus which phase of a word we are in.
  int m_count, m_wr, m_rd, m_left;
  bit m_fetch, m_present, m_done, m_err;
  bit e_ready, e_store, idle, nf, np, nd, ne;
  int nl;

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_rst_res_ready", res_ready, 0);
      chk("m_rst_ext_valid", ext_valid, 0);
      chk("m_rst_store", st_stb, 0);
      chk("m_rst_send", sd_stb, 0);
      chk("m_rst_done", drain_done, 0);
      chk("m_rst_err", drain_err, 0);
      chk("m_rst_full", full, 0);
      chk("m_rst_empty", empty, 1);
      chk("m_rst_count", count, 0);
      m_count = 0; m_wr = 0; m_rd = 0; m_left = 0;
      m_fetch = 0; m_present = 0; m_done = 0; m_err = 0;
    end else begin
      e_ready = (m_count < 16) && !m_fetch;
      e_store = res_valid && e_ready;
      chk("m_res_ready", res_ready, e_ready);
      chk("m_store", st_stb, e_store);
      chk("m_store_addr", st_addr, m_wr);
      chk("m_send", sd_stb, m_fetch);
      chk("m_send_addr", sd_addr, m_rd);
      chk("m_ext_valid", ext_valid, m_present);
      chk("m_done", drain_done, m_done);
      chk("m_err", drain_err, m_err);
      chk("m_count", count, m_count);
      chk("m_full", full, m_count == 16);
      chk("m_empty", empty, m_count == 0);

      nf = 0; np = 0; nd = 0; ne = 0; nl = m_left;
      idle = !m_fetch && !m_present && !m_done;
      if (idle && drain_start) begin
        if (drain_count >= 1 && int'(drain_count) <= m_count) begin
          nl = drain_count;
          nf = 1;
        end else begin
          ne = 1;
        end
      end
      if (m_fetch) begin
        m_rd = (m_rd + 1) % 16;
        m_count--;
        np = 1;
      end
      if (m_present) begin
        if (ext_ready) begin
          nl = m_left - 1;
          if (nl == 0) nd = 1;
          else nf = 1;
        end else begin
          np = 1;
        end
      end
      if (e_store) begin
        m_wr = (m_wr + 1) % 16;
        m_count++;
      end
      m_left = nl; m_fetch = nf; m_present = np; m_done = nd; m_err = ne;
    end
  end

  int bad_counts[2] = '{5, 0};
  bit e_send[5]  = '{1, 0, 1, 0, 0};
  bit e_valid[5] = '{0, 1, 0, 1, 0};
  bit e_done[5]  = '{0, 0, 0, 0, 1};
  int e_addr[5]  = '{0, 0, 1, 1, 1};
  bit got;

  initial begin
    rst = 1'b0; res_valid = 1'b0; drain_start = 1'b0; drain_count = 5'd0; ext_ready = 1'b0;
    step(); step();
    @(negedge clk);
    chk("rst_empty", empty, 1);
    chk("rst_res_ready", res_ready, 0);
    step();
    rst = 1'b1;

    // Three back-to-back stores land at addresses 0,1,2.
    res_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s037_store", st_stb, 1);
      chk("s037_addr", st_addr, i);
      step();
    end
    res_valid = 1'b0;
    @(negedge clk);
    chk("s037_count", count, 3);
    chk("s037_empty", empty, 0);

    // Illegal drain counts pulse drain_err and never start a read.
    foreach (bad_counts[b]) begin
      step();
      drain_start = 1'b1; drain_count = 5'(bad_counts[b]);
      step();
      drain_start = 1'b0;
      @(negedge clk);
      chk("s041_err", drain_err, 1);
      chk("s041_no_send", sd_stb, 0);
      step();
      @(negedge clk);
      chk("s041_err_clear", drain_err, 0);
      chk("s041_idle", sd_stb, 0);
    end

    // Drain two with the consumer always ready: fixed cycle schedule.
    step();
    drain_start = 1'b1; drain_count = 5'd2; ext_ready = 1'b1;
    step();
    drain_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("s039_send", sd_stb, e_send[k]);
      chk("s039_valid", ext_valid, e_valid[k]);
      chk("s039_done", drain_done, e_done[k]);
      if (e_send[k]) chk("s039_addr", sd_addr, e_addr[k]);
      step();
    end
    @(negedge clk);
    chk("s039_count", count, 1);

    // Store stalled in RD then taken in WAIT; consumer stalls for 5 cycles.
    step();
    drain_start = 1'b1; drain_count = 5'd1; ext_ready = 1'b0;
    step();
    drain_start = 1'b0; res_valid = 1'b1;
    @(negedge clk);
    chk("s042_rd_ready", res_ready, 0);
    chk("s042_rd_store", st_stb, 0);
    chk("s042_rd_send", sd_stb, 1);
    step();
    drain_start = 1'b1; drain_count = 5'd9;
    @(negedge clk);
    chk("s042_wait_store", st_stb, 1);
    chk("s042_wait_addr", st_addr, 3);
    chk("s040_valid0", ext_valid, 1);
    step();
    drain_start = 1'b0; res_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (j == 0) chk("s023_ignored", drain_err, 0);
      chk("s040_valid", ext_valid, 1);
      chk("s040_no_send", sd_stb, 0);
      chk("s040_rd_ptr", sd_addr, 3);
      step();
    end
    ext_ready = 1'b1;
    @(negedge clk);
    chk("s040_valid_last", ext_valid, 1);
    step();
    @(negedge clk);
    chk("s040_done", drain_done, 1);
    step();

    // Reset while in WAIT abandons the drain immediately.
    drain_start = 1'b1; drain_count = 5'd1; ext_ready = 1'b0;
    step();
    drain_start = 1'b0;
    step();
    @(negedge clk);
    chk("s042_in_wait", ext_valid, 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("s042_rst_valid", ext_valid, 0);
    chk("s042_rst_ready", res_ready, 0);
    chk("s042_rst_send", sd_stb, 0);
    chk("s042_rst_store", st_stb, 0);
    chk("s042_rst_done", drain_done, 0);
    chk("s042_rst_err", drain_err, 0);
    chk("s042_rst_full", full, 0);
    chk("s042_rst_empty", empty, 1);
    step(); step();
    @(negedge clk);
    chk("s035_no_done", drain_done, 0);
    step();
    rst = 1'b1;

    // Fill to 16, refuse the 17th, drain all, then the write pointer wraps.
    res_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("s038_fill_addr", st_addr, i);
      chk("s038_fill_store", st_stb, 1);
      step();
    end
    @(negedge clk);
    chk("s038_full", full, 1);
    chk("s038_ready17", res_ready, 0);
    chk("s038_store17", st_stb, 0);
    step();
    res_valid = 1'b0;
    drain_start = 1'b1; drain_count = 5'd16; ext_ready = 1'b1;
    step();
    drain_start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (drain_done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("s038_drain_done", got, 1);
    step();
    res_valid = 1'b1;
    @(negedge clk);
    chk("s038_wrap_store", st_stb, 1);
    chk("s038_wrap_addr", st_addr, 0);
    step();
    res_valid = 1'b0;
    @(negedge clk);
    chk("s038_wrap_count", count, 1);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
